// File: rtl/attr_text_renderer_pkg.sv
// attr_text_renderer_pkg: cell layout, FSM states, RGB type and palette reset values
package attr_text_renderer_pkg;
  localparam int CELL_BITS = 16;
  localparam int CODE_LSB  = 0;
  localparam int CODE_W    = 8;
  localparam int FG_LSB    = 8;
  localparam int BG_LSB    = 12;
  localparam int IDX_W     = 4;
  typedef enum logic [2:0] {SWAP, TEXT_WAIT, FONT_ADDR, FONT_WAIT, EMIT, DONE} state_e;
  typedef logic [23:0] rgb_t;
  function automatic rgb_t pal_reset(input logic [IDX_W-1:0] i);
    return {6{i}};
  endfunction
endpackage

// File: rtl/attr_text_renderer_text_palette.sv
// text_palette: 16-entry RGB888 palette, one write port, two combinational read ports
module text_palette
  import attr_text_renderer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  rgb_t             wdata_i,
  input  logic [IDX_W-1:0] fg_idx_i,
  input  logic [IDX_W-1:0] bg_idx_i,
  output rgb_t             fg_o,
  output rgb_t             bg_o
);
  rgb_t pal_q [16];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 16; i++) pal_q[i] <= pal_reset(IDX_W'(i));
    else if (we_i) pal_q[widx_i] <= wdata_i;
  assign fg_o = pal_q[fg_idx_i];
  assign bg_o = pal_q[bg_idx_i];
endmodule

// File: rtl/attr_text_renderer.sv
// attr_text_renderer: double-buffered text-mode cell renderer; CURSOR_BLINK_EN adds a frame-based cursor blink
module attr_text_renderer
  import attr_text_renderer_pkg::*;
#(
  parameter int COLUMNS      = 80,
  parameter int LINES        = 30,
  parameter int CELL_WORDS   = 16,
  parameter int ADDR_W       = 20,
  parameter int FONT_W       = 128,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       paint_done,
  output logic [$clog2(LINES)-1:0]   text_addr,
  input  logic [CELL_BITS*COLUMNS-1:0] text_data,
  output logic [7:0]                 font_addr,
  input  logic [FONT_W-1:0]          font_data,
  output logic                       cell_valid,
  input  logic                       cell_ready,
  output logic [FONT_W-1:0]          cell_shape,
  output rgb_t                       cell_fg,
  output rgb_t                       cell_bg,
  output logic [ADDR_W-1:0]          cell_base,
  output logic [ADDR_W-1:0]          vga_base,
  input  logic                       cursor_en,
  input  logic [6:0]                 cursor_col,
  input  logic [5:0]                 cursor_line,
  input  logic                       pal_we,
  input  logic [3:0]                 pal_idx,
  input  rgb_t                       pal_data,
  output logic                       frame_done
);
  localparam int CW = $clog2(COLUMNS);
  localparam int LW = $clog2(LINES);
  localparam logic [ADDR_W-1:0] BUF_WORDS = ADDR_W'(LINES * COLUMNS * CELL_WORDS);
  state_e                       state_q;
  logic                         buf_sel_q;
  logic [CW-1:0]                col_q;
  logic [LW-1:0]                line_q;
  logic [CELL_BITS*COLUMNS-1:0] text_q;
  logic [IDX_W-1:0]             fg_idx_q, bg_idx_q;
  logic                         phase;
  rgb_t                         pal_fg, pal_bg;
  logic [CELL_BITS-1:0]         cell_w;
  logic                         hit, last_col, last_line;
  logic [ADDR_W-1:0]            render_base, offs;
  text_palette u_pal (
    .clk(clk), .rst(rst), .we_i(pal_we), .widx_i(pal_idx), .wdata_i(pal_data),
    .fg_idx_i(fg_idx_q), .bg_idx_i(bg_idx_q), .fg_o(pal_fg), .bg_o(pal_bg)
  );
  assign cell_w      = text_q[CELL_BITS*col_q +: CELL_BITS];
  assign last_col    = 32'(col_q) == COLUMNS - 1;
  assign last_line   = 32'(line_q) == LINES - 1;
  assign hit         = cursor_en && phase && 32'(cursor_col) == 32'(col_q) && 32'(cursor_line) == 32'(line_q);
  assign render_base = buf_sel_q ? BUF_WORDS : '0;
  assign vga_base    = buf_sel_q ? '0 : BUF_WORDS;
  assign offs        = ADDR_W'((32'(line_q) * COLUMNS + 32'(col_q)) * CELL_WORDS);
  assign text_addr   = line_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SWAP;
      buf_sel_q  <= 1'b0;
      col_q      <= '0;
      line_q     <= '0;
      text_q     <= '0;
      fg_idx_q   <= '0;
      bg_idx_q   <= '0;
      font_addr  <= '0;
      cell_valid <= 1'b0;
      cell_shape <= '0;
      cell_fg    <= '0;
      cell_bg    <= '0;
      cell_base  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        SWAP: begin
          buf_sel_q <= ~buf_sel_q;
          col_q     <= '0;
          line_q    <= '0;
          state_q   <= TEXT_WAIT;
        end
        TEXT_WAIT: begin
          text_q  <= text_data;
          state_q <= FONT_ADDR;
        end
        FONT_ADDR: begin
          font_addr <= cell_w[CODE_LSB +: CODE_W];
          fg_idx_q  <= cell_w[FG_LSB +: IDX_W];
          bg_idx_q  <= cell_w[BG_LSB +: IDX_W];
          state_q   <= FONT_WAIT;
        end
        FONT_WAIT: begin
          cell_shape <= font_data;
          cell_fg    <= hit ? pal_bg : pal_fg;
          cell_bg    <= hit ? pal_fg : pal_bg;
          cell_base  <= render_base + offs;
          cell_valid <= 1'b1;
          state_q    <= EMIT;
        end
        EMIT: if (cell_ready) begin
          cell_valid <= 1'b0;
          if (!last_col) begin
            col_q   <= col_q + 1'b1;
            state_q <= FONT_ADDR;
          end else if (!last_line) begin
            col_q   <= '0;
            line_q  <= line_q + 1'b1;
            state_q <= TEXT_WAIT;
          end else begin
            frame_done <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: if (paint_done) state_q <= SWAP;
        default: state_q <= SWAP;
      endcase
    end
  end
`ifdef CURSOR_BLINK_EN
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_q;
  logic          phase_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (frame_done) begin
      blink_q <= blink_q == BW'(BLINK_FRAMES - 1) ? '0 : blink_q + 1'b1;
      phase_q <= blink_q == BW'(BLINK_FRAMES - 1) ? ~phase_q : phase_q;
    end
  end
  assign phase = phase_q;
`else
  assign phase = (BLINK_FRAMES | 1) != 0;
`endif
endmodule

// File: tb/tb_attr_text_renderer.sv
// tb_attr_text_renderer: randomized scoreboard bench for attr_text_renderer
module tb_attr_text_renderer;
  localparam int C = 4, L = 2, CWD = 16, AW = 20, FW = 128;
  localparam int BUF = L * C * CWD;
  typedef struct packed {
    logic [FW-1:0] shape;
    logic [23:0]   fg, bg;
    logic [AW-1:0] base, vga;
  } exp_t;

  logic clk, rst, paint_done, cell_valid, cell_ready, cursor_en, pal_we, frame_done;
  logic [$clog2(L)-1:0] text_addr;
  logic [16*C-1:0] text_data;
  logic [7:0] font_addr;
  logic [FW-1:0] font_data, cell_shape;
  logic [23:0] cell_fg, cell_bg, pal_data;
  logic [AW-1:0] cell_base, vga_base;
  logic [6:0] cursor_col;
  logic [5:0] cursor_line;
  logic [3:0] pal_idx;

  attr_text_renderer #(.COLUMNS(C), .LINES(L), .CELL_WORDS(CWD), .ADDR_W(AW), .FONT_W(FW), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .paint_done(paint_done), .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_shape(cell_shape), .cell_fg(cell_fg), .cell_bg(cell_bg), .cell_base(cell_base),
    .vga_base(vga_base), .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_line(cursor_line),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data), .frame_done(frame_done)
  );

  int checks = 0, errors = 0, cyc = 0, rmode = 0;
  exp_t q[$];
  logic [15:0] txt [L][C];
  logic [23:0] pal_m [16];
  int pend_t[$];
  logic [3:0] pend_i[$];
  logic [23:0] pend_d[$];

  function automatic logic [FW-1:0] glyph(input logic [7:0] c);
    return {16{c ^ 8'hA5}};
  endfunction

  assign font_data = glyph(font_addr);
  always_comb begin
    text_data = '0;
    for (int c = 0; c < C; c++) text_data[16*c +: 16] = txt[text_addr][c];
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
  initial begin
    cell_ready = 1;
    forever begin
      @(posedge clk);
      #1 cell_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  // Monitor: pops on every handshake, and checks outputs held while stalled
  initial begin
    exp_t e, p;
    bit stall = 0;
    forever begin
      @(negedge clk);
      if (rst) stall = 0;
      else begin
        if (stall) begin
          checks++;
          if (!cell_valid || {cell_shape, cell_fg, cell_bg, cell_base} !== {p.shape, p.fg, p.bg, p.base}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b fg=%h bg=%h base=%h expected v=1 fg=%h bg=%h base=%h",
                     cell_valid, cell_fg, cell_bg, cell_base, p.fg, p.bg, p.base);
          end
        end
        stall = cell_valid && !cell_ready;
        p = '{cell_shape, cell_fg, cell_bg, cell_base, vga_base};
        if (cell_valid && cell_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL cell: got unexpected cell base=%h expected no cell", cell_base);
          end else begin
            e = q.pop_front();
            if (p !== e) begin
              errors++;
              $display("FAIL cell: got shape=%h fg=%h bg=%h base=%h vga=%h expected shape=%h fg=%h bg=%h base=%h vga=%h",
                       p.shape, p.fg, p.bg, p.base, p.vga, e.shape, e.fg, e.bg, e.base, e.vga);
            end
          end
        end
      end
    end
  end

  function automatic logic [23:0] lookup(input logic [3:0] idx, input int t);
    logic [23:0] r = pal_m[idx];
    foreach (pend_t[i]) if (pend_i[i] == idx && pend_t[i] < t) r = pend_d[i];
    return r;
  endfunction

  // Lookup edge t counts clock edges from reset release; only meaningful for the first frame
  task automatic push_frame(input bit hi);
    exp_t e;
    logic [15:0] w;
    logic [23:0] fg, bg;
    bit hit;
    for (int l = 0; l < L; l++)
      for (int c = 0; c < C; c++) begin
        int k = l * C + c;
        w = txt[l][c];
        fg = lookup(w[11:8], 4 + l + 3 * k);
        bg = lookup(w[15:12], 4 + l + 3 * k);
        hit = cursor_en && int'(cursor_col) == c && int'(cursor_line) == l;
        e.shape = glyph(w[7:0]);
        e.fg = hit ? bg : fg;
        e.bg = hit ? fg : bg;
        e.base = AW'((hi ? BUF : 0) + k * CWD);
        e.vga = AW'(hi ? 0 : BUF);
        q.push_back(e);
      end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic pal_wr_at(input int e, input logic [3:0] i, input logic [23:0] d);
    wait_cyc(e - 1);
    pal_we = 1; pal_idx = i; pal_data = d;
    @(posedge clk);
    #1 pal_we = 0;
  endtask
  task automatic pal_wr_now(input logic [3:0] i, input logic [23:0] d);
    @(negedge clk);
    pal_we = 1; pal_idx = i; pal_data = d;
    @(posedge clk);
    #1 pal_we = 0;
    pal_m[i] = d;
  endtask
  task automatic pulse_pd;
    @(negedge clk) paint_done = 1;
    @(negedge clk) paint_done = 0;
  endtask
  task automatic wait_frame(output int at);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        at = cyc;
        return;
      end
    end
    at = -1;
    checks++; errors++;
    $display("FAIL frame_timeout: got no frame_done expected one within 3000 cycles");
  endtask
  task automatic wait_valid;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cell_valid) return;
    end
    checks++; errors++;
    $display("FAIL valid_timeout: got no cell_valid expected one within 200 cycles");
  endtask
  task automatic rand_text;
    for (int l = 0; l < L; l++) for (int c = 0; c < C; c++) txt[l][c] = 16'($urandom);
  endtask
  task automatic reset_pal;
    for (int i = 0; i < 16; i++) pal_m[i] = {6{4'(i)}};
  endtask

  initial begin
    int at;
    bit seen;
    rst = 1; paint_done = 0; pal_we = 0; pal_idx = 0; pal_data = 0;
    cursor_en = 0; cursor_col = 0; cursor_line = 0;
    reset_pal();
    rand_text();
    repeat (3) @(negedge clk);
    chk("rst_valid", cell_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_text_addr", text_addr, 0);
    chk("rst_font_addr", font_addr, 0);
    chk("rst_vga_base", vga_base, BUF);
    chk("rst_shape", cell_shape, 0);
    chk("rst_fg", cell_fg, 0);
    chk("rst_bg", cell_bg, 0);

    // Frame 0: fixed text, cursor (1,1), timed palette writes, stray paint_done
    txt[0][0] = 16'h2F41; txt[0][1] = 16'h3F42; txt[0][2] = 16'h1E43; txt[0][3] = 16'h0544;
    txt[1][0] = 16'h7A61; txt[1][1] = 16'h4B62; txt[1][2] = 16'h9C63; txt[1][3] = 16'hFD64;
    cursor_en = 1; cursor_col = 1; cursor_line = 1;
    pend_t = '{6, 10}; pend_i = '{4'd15, 4'd14}; pend_d = '{24'hFF0000, 24'h00FF00};
    push_frame(1);
    @(negedge clk) rst = 0;
    fork
      pal_wr_at(6, 15, 24'hFF0000);
      pal_wr_at(10, 14, 24'h00FF00);
      begin wait_cyc(11); paint_done = 1; @(posedge clk); #1 paint_done = 0; end
      begin wait_cyc(3); chk("valid_before_c4", cell_valid, 0); wait_cyc(4); chk("first_valid_c4", cell_valid, 1); end
      wait_frame(at);
    join
    chk("frame0_cycles", at, 27);
    pal_m[15] = 24'hFF0000; pal_m[14] = 24'h00FF00;
    pend_t.delete(); pend_i.delete(); pend_d.delete();
    seen = 0;
    repeat (6) begin @(negedge clk); seen |= cell_valid; end
    chk("done_ignores_early_paint", seen, 0);
    chk("vga_frame0", vga_base, 0);

    // Frame 1: out-of-range cursor, ready held low 5 cycles on first cell
    rand_text();
    cursor_col = 90; cursor_line = 1;
    rmode = 2;
    push_frame(0);
    pulse_pd();
    wait_valid();
    repeat (5) @(negedge clk);
    rmode = 0;
    wait_frame(at);
    chk("vga_frame1", vga_base, BUF);

    // Frames 2..5: random palette, text, cursor and backpressure
    for (int f = 2; f < 6; f++) begin
      repeat (2) pal_wr_now(4'($urandom), 24'($urandom));
      rand_text();
      cursor_en = 1'($urandom);
      cursor_col = 7'($urandom_range(0, 5));
      cursor_line = 6'($urandom_range(0, 2));
      rmode = 1;
      push_frame(f % 2 == 0);
      pulse_pd();
      wait_frame(at);
    end

    // Frame 6: reset while a cell is stalled, then restart from cell (0,0)
    rand_text();
    rmode = 2;
    push_frame(1);
    pulse_pd();
    wait_valid();
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_valid", cell_valid, 0);
    chk("midrst_vga", vga_base, BUF);
    chk("midrst_text_addr", text_addr, 0);
    q.delete();
    reset_pal();
    rand_text();
    cursor_en = 0;
    rmode = 0;
    push_frame(1);
    @(negedge clk) rst = 0;
    wait_cyc(4);
    chk("restart_first_valid", cell_valid, 1);
    wait_frame(at);
    chk("restart_cycles", at, 27);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/attr_text_renderer.md
# attr_text_renderer

Parametrised, attribute-aware text-mode frame renderer. Walks a COLUMNS x LINES character grid line by line, fetches each line from text RAM and each glyph from font ROM, and resolves per-cell 4-bit colour indices through a writable 16-entry palette. It overlays a cursor and hands each finished cell to a downstream cell writer over a valid/ready handshake. It double-buffers the frame store, swapping the VGA scan-out and render buffers once per rendered frame.

## Interface
Parameters:
- COLUMNS, 80, cells per line
- LINES, 30, lines per frame
- CELL_WORDS, 16, frame-store words per cell
- ADDR_W, 20, frame-store address width
- FONT_W, 128, glyph bitmap width
- BLINK_FRAMES, 32, frames per cursor blink phase (used only with CURSOR_BLINK_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- paint_done  in  1  VGA finished scanning the current display buffer
- text_addr  out  $clog2(LINES)  text RAM line address
- text_data  in  16*COLUMNS  line word, 1-cycle read latency; cell c occupies [16c+15:16c] = {bg_idx[3:0], fg_idx[3:0], code[7:0]}
- font_addr  out  8  font ROM address (character code)
- font_data  in  FONT_W  glyph, 1-cycle read latency
- cell_valid  out  1  cell output valid
- cell_ready  in  1  cell writer accepts
- cell_shape  out  FONT_W  glyph bitmap
- cell_fg, cell_bg  out  24  resolved RGB888
- cell_base  out  ADDR_W  frame-store base address of the cell
- vga_base  out  ADDR_W  display buffer base address
- cursor_en  in  1  cursor visible
- cursor_col  in  7  cursor column
- cursor_line  in  6  cursor line
- pal_we  in  1  palette write strobe
- pal_idx  in  4  palette entry
- pal_data  in  24  palette RGB
- frame_done  out  1  one-cycle pulse, last cell accepted

## Operation
- BUF_WORDS = LINES*COLUMNS*CELL_WORDS.
- buf_sel=1: vga_base=0, render_base=BUF_WORDS. buf_sel=0: the two bases are swapped.
- cell_base = render_base + (line*COLUMNS + col)*CELL_WORDS. Computed at ADDR_W width; the product is truncated and never wraps into the other buffer for legal parameters.
- States:
  - SWAP: toggle buf_sel, line=col=0, text_addr=0 → TEXT_WAIT.
  - TEXT_WAIT: latch text_data into the line register → FONT_ADDR.
  - FONT_ADDR: font_addr = code of cell col; latch fg_idx/bg_idx → FONT_WAIT.
  - FONT_WAIT: register font_data into cell_shape; resolve cell_fg/cell_bg from the palette; apply the cursor; set cell_valid → EMIT.
  - EMIT: hold all cell outputs stable until cell_valid&&cell_ready. On the handshake:
    - col<COLUMNS-1 → col+1, FONT_ADDR.
    - Else if line<LINES-1 → col=0, line+1, text_addr=line+1, TEXT_WAIT.
    - Else → pulse frame_done, DONE.
  - DONE: paint_done=1 → SWAP. paint_done in any other state is ignored, not latched.
- Cursor: when cursor_en, (cursor_col,cursor_line)==(col,line) and the phase is on, swap cell_fg and cell_bg. Out-of-range cursor coordinates never match. Cursor inputs are sampled in FONT_WAIT.
- Palette: 16x24 registers, reset entry i = {i,i,i,i,i,i} (entry 0 = 000000, 7 = 777777, 15 = FFFFFF).
  - A write is visible from the next cycle.
  - A lookup in the same cycle as a write to the same entry returns the old value.
- Reset values: state SWAP, buf_sel=0 (vga_base=BUF_WORDS), line=col=0, cell_valid=0, frame_done=0, text_addr=0, font_addr=0, cell_shape/fg/bg=0, blink counter and phase 0.
- Reset mid-frame aborts immediately; no partial handshake completes.

## Timing
- First cell_valid occurs 4 cycles after reset release: SWAP, TEXT_WAIT, FONT_ADDR, FONT_WAIT.
- Per cell: 3 cycles (FONT_ADDR, FONT_WAIT, EMIT) with cell_ready tied high.
- Line change adds 1 cycle (TEXT_WAIT).
- Frame with cell_ready=1: 1 + LINES + 3*LINES*COLUMNS cycles from SWAP to frame_done.
- cell_valid is never deasserted without a handshake.

## Configuration
- CURSOR_BLINK_EN defined: a frame counter increments on each frame_done and toggles the phase every BLINK_FRAMES frames. The cursor is inverted only in phase 1, and the phase is 0 after reset.
- Not defined: phase is constant 1, so the cursor is always inverted when cursor_en is set. No counter is built.

## Structure
- The shared package holds:
  - Cell bit-field layout constants.
  - The state enum.
  - The RGB888 typedef.
  - The palette reset function.
- One sub-module, text_palette: the 16-entry register file with a write port and two combinational read ports.

## Test plan
- COLUMNS=4, LINES=2, cell_ready=1, cell 0 = 16'h2F41 → font_addr=8'h41, cell_fg=FFFFFF, cell_bg=222222, cell_base=BUF_WORDS; frame_done at cycle 1+2+24.
- cell_ready held low for 5 cycles in EMIT → cell_valid and all cell outputs stable, col unchanged; advances the cycle after ready.
- pal_we idx 15 = 24'hFF0000 one cycle before FONT_WAIT of a fg=15 cell → cell_fg=FF0000. A write in the same cycle as FONT_WAIT → old FFFFFF.
- cursor (1,1), cursor_en=1, no macro → cell (1,1) has fg/bg swapped, all others normal. cursor_col=90 → no swap.
- Two frames with paint_done pulses → vga_base alternates 0, BUF_WORDS. paint_done during render is ignored.
- rst asserted mid-EMIT → cell_valid=0 and state SWAP immediately; restart renders from cell (0,0).
